// File: rtl/mips32_run_ctrl.sv
// Load/run/dump sequencer for the pipelined MIPS32 core: streams a program into
// instruction memory, releases the core until HLT or budget, then dumps R0..R(DUMP_REGS-1).
// Define MIPS32_RUN_CTRL_DUMP_EN to build the register-dump state; otherwise RUN ends in DONE.
module mips32_run_ctrl #(
  parameter int unsigned MEM_AW    = 10,
  parameter int unsigned DUMP_REGS = 6,
  parameter int unsigned CYC_W     = 16
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              core_init,
  input  logic              core_halted,
  input  logic [CYC_W-1:0]  max_cycles,
  output logic [4:0]        reg_raddr,
  input  logic [31:0]       reg_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic [4:0]        dump_idx,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              load_ovf,
  output logic [CYC_W-1:0]  run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              timeout_q, timeout_d;
  logic              ovf_q, ovf_d;
  logic              ld_acc;
  logic              budget_hit;

`ifdef MIPS32_RUN_CTRL_DUMP_EN
  localparam logic [4:0] LAST_IDX = 5'(DUMP_REGS - 1);
  logic [4:0] idx_q, idx_d;
`endif

  assign ld_acc     = ld_valid && (state_q == S_LOAD);
  assign budget_hit = (max_cycles != '0) && (cyc_q == max_cycles - CYC_W'(1));

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef MIPS32_RUN_CTRL_DUMP_EN
      idx_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
      ovf_q     <= ovf_d;
`ifdef MIPS32_RUN_CTRL_DUMP_EN
      idx_q     <= idx_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
    ovf_d     = ovf_q;
`ifdef MIPS32_RUN_CTRL_DUMP_EN
    idx_d     = idx_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_LOAD;
          addr_d    = '0;
          cyc_d     = '0;
          timeout_d = 1'b0;
          ovf_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (ld_acc) begin
          addr_d = addr_q + MEM_AW'(1);
          if (ld_last) begin
            state_d = S_INIT;
          end else if (&addr_q) begin
            // Memory full: stop loading rather than wrap onto address 0.
            ovf_d   = 1'b1;
            addr_d  = addr_q;
            state_d = S_INIT;
          end
        end
      end
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (~&cyc_q) cyc_d = cyc_q + CYC_W'(1);
        if (core_halted || budget_hit) begin
          timeout_d = !core_halted;
`ifdef MIPS32_RUN_CTRL_DUMP_EN
          idx_d   = '0;
          state_d = S_DUMP;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef MIPS32_RUN_CTRL_DUMP_EN
      S_DUMP: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else idx_d = idx_q + 5'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign ld_ready   = (state_q == S_LOAD);
  assign mem_we     = ld_acc;
  assign mem_addr   = ld_acc ? addr_q : '0;
  assign mem_wdata  = ld_acc ? ld_data : '0;
  assign core_hold  = (state_q != S_RUN);
  assign core_init  = (state_q == S_INIT);
  assign busy       = (state_q == S_LOAD) || (state_q == S_INIT) ||
                      (state_q == S_RUN)  || (state_q == S_DUMP);
  assign done       = (state_q == S_DONE);
  assign timeout    = timeout_q;
  assign load_ovf   = ovf_q;
  assign run_cycles = cyc_q;

`ifdef MIPS32_RUN_CTRL_DUMP_EN
  assign dump_valid = (state_q == S_DUMP);
  assign reg_raddr  = dump_valid ? idx_q : '0;
  assign dump_idx   = dump_valid ? idx_q : '0;
  assign dump_data  = dump_valid ? reg_rdata : '0;
`else
  logic unused_dump;
  assign unused_dump = ^{dump_ready, reg_rdata, 5'(DUMP_REGS)};
  assign dump_valid  = 1'b0;
  assign reg_raddr   = '0;
  assign dump_idx    = '0;
  assign dump_data   = '0;
`endif

endmodule
